// File: rtl/periph_gpio_pkg.sv
// Shared register map and helpers for the APB GPIO controller.
// Offsets are byte addresses; reg_idx_e is the paddr[4:2] word index.
package periph_gpio_pkg;

  localparam int GPIO_MAX = 32;

  localparam logic [7:0] OFF_DOUT     = 8'h00;
  localparam logic [7:0] OFF_OE       = 8'h04;
  localparam logic [7:0] OFF_DIN      = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_RISE_EN  = 8'h10;
  localparam logic [7:0] OFF_FALL_EN  = 8'h14;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h18;
  localparam logic [7:0] OFF_UNMAPPED = 8'h1C;

  typedef enum logic [2:0] {
    REG_DOUT     = 3'd0,
    REG_OE       = 3'd1,
    REG_DIN      = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_RISE_EN  = 3'd4,
    REG_FALL_EN  = 3'd5,
    REG_IRQ_STAT = 3'd6,
    REG_UNMAPPED = 3'd7
  } reg_idx_e;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/periph_gpio_edge.sv
// Two-flop input synchroniser plus per-bit rise/fall detection.
// Synchronised value is exported as DIN; edges are gated by their enables.
module periph_gpio_edge #(
  parameter int GPIO = 32
) (
  input  logic            pclk,
  input  logic            preset_n,
  input  logic [GPIO-1:0] gpio_i,
  input  logic [GPIO-1:0] rise_en,
  input  logic [GPIO-1:0] fall_en,
  output logic [GPIO-1:0] din,
  output logic [GPIO-1:0] rise,
  output logic [GPIO-1:0] fall
);

  logic [GPIO-1:0] sync_p0;
  logic [GPIO-1:0] sync_p1;
  logic [GPIO-1:0] prev_p2;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      // p0: metastability capture, p1: stable sample, p2: previous stable sample
      sync_p0 <= gpio_i;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign din  = sync_p1;
  assign rise =  sync_p1 & ~prev_p2 & rise_en;
  assign fall = ~sync_p1 &  prev_p2 & fall_en;

endmodule

// File: rtl/periph_gpio_apb.sv
// Zero-wait APB4 GPIO controller: register file, byte-strobed writes,
// W1C edge status and a registered level interrupt.
module periph_gpio_apb
  import periph_gpio_pkg::*;
#(
  parameter int GPIO = 32,
  parameter int ADDR = 16,
  parameter int DATA = 32
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic [2:0]        pprot,
  input  logic [ADDR-1:0]   paddr,
  input  logic              pwrite,
  input  logic [DATA-1:0]   pwdata,
  input  logic [DATA/8-1:0] pstrb,
  output logic [DATA-1:0]   prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [GPIO-1:0]   gpio_i,
  output logic [GPIO-1:0]   gpio_o,
  output logic [GPIO-1:0]   gpio_e,
  output logic              irq
);

  logic [GPIO-1:0] dout_q, oe_q, irq_en_q, rise_en_q, fall_en_q, stat_q;
  logic            irq_q;
  logic [GPIO-1:0] din, rise, fall;
  logic [GPIO-1:0] wmask, wdata, w1c;
  logic [DATA-1:0] bmask, rdata;
  logic            access, wr_en, rd_en;
  reg_idx_e        idx;

  function automatic logic [GPIO-1:0] merge(input logic [GPIO-1:0] cur,
                                            input logic [GPIO-1:0] nxt,
                                            input logic [GPIO-1:0] msk);
    return (cur & ~msk) | (nxt & msk);
  endfunction

  assign access = psel & penable;
  assign wr_en  = access & pwrite;
  assign rd_en  = access & ~pwrite;
  assign idx    = reg_idx_e'(paddr[4:2]);
  assign bmask  = strb_mask(pstrb);
  assign wmask  = bmask[GPIO-1:0];
  assign wdata  = pwdata[GPIO-1:0];
  assign w1c    = (wr_en && idx == REG_IRQ_STAT) ? (wdata & wmask) : '0;

  logic unused_ok;
  assign unused_ok = ^{pprot, paddr, pwdata, bmask};

  periph_gpio_edge #(.GPIO(GPIO)) u_edge (
    .pclk     (pclk),
    .preset_n (preset_n),
    .gpio_i   (gpio_i),
    .rise_en  (rise_en_q),
    .fall_en  (fall_en_q),
    .din      (din),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      dout_q    <= '0;
      oe_q      <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (idx)
          REG_DOUT:    dout_q    <= merge(dout_q, wdata, wmask);
          REG_OE:      oe_q      <= merge(oe_q, wdata, wmask);
          REG_IRQ_EN:  irq_en_q  <= merge(irq_en_q, wdata, wmask);
          REG_RISE_EN: rise_en_q <= merge(rise_en_q, wdata, wmask);
          REG_FALL_EN: fall_en_q <= merge(fall_en_q, wdata, wmask);
          default: ;
        endcase
      end
      // A fresh edge overrides a clear landing in the same cycle
      stat_q <= (stat_q & ~w1c) | rise | fall;
      irq_q  <= |(stat_q & irq_en_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (idx)
        REG_DOUT:     rdata = DATA'(dout_q);
        REG_OE:       rdata = DATA'(oe_q);
        REG_DIN:      rdata = DATA'(din);
        REG_IRQ_EN:   rdata = DATA'(irq_en_q);
        REG_RISE_EN:  rdata = DATA'(rise_en_q);
        REG_FALL_EN:  rdata = DATA'(fall_en_q);
        REG_IRQ_STAT: rdata = DATA'(stat_q);
        default:      rdata = '0;
      endcase
    end
  end

  assign prdata  = rdata;
  assign pslverr = access & (idx == REG_UNMAPPED);
  assign pready  = 1'b1;
  assign gpio_o  = dout_q;
  assign gpio_e  = oe_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_periph_gpio_apb.sv
// Bench for periph_gpio_apb: a 32-pin and an 8-pin instance share one APB bus;
// read expectations are queued before each read and popped when prdata is sampled.
module tb_periph_gpio_apb;
  import periph_gpio_pkg::*;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  pprot = 3'b000;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] gpio_i = '0;

  logic [31:0] prdata32, prdata8;
  logic        pready32, pready8, pslverr32, pslverr8, irq32, irq8;
  logic [31:0] gpio_o32, gpio_e32;
  logic [7:0]  gpio_o8, gpio_e8;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        use8 = 1'b0;
  logic [31:0] exp_q[$];

  always #5 pclk = ~pclk;

  periph_gpio_apb #(.GPIO(32), .ADDR(16), .DATA(32)) u_dut32 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pprot(pprot),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata32), .pready(pready32), .pslverr(pslverr32),
    .gpio_i(gpio_i), .gpio_o(gpio_o32), .gpio_e(gpio_e32), .irq(irq32)
  );

  periph_gpio_apb #(.GPIO(8), .ADDR(16), .DATA(32)) u_dut8 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pprot(pprot),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata8), .pready(pready8), .pslverr(pslverr8),
    .gpio_i(gpio_i[7:0]), .gpio_o(gpio_o8), .gpio_e(gpio_e8), .irq(irq8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_err, input string tag);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2;
    check_val({tag, "_err"}, use8 ? 32'(pslverr8) : 32'(pslverr32), 32'(exp_err));
    check_val({tag, "_rd0"}, use8 ? prdata8 : prdata32, 32'h0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] addr, input logic exp_err, input string tag);
    logic [31:0] exp;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s got=0x%08h exp=<queue empty>", tag, use8 ? prdata8 : prdata32);
    end else begin
      exp = exp_q.pop_front();
      check_val(tag, use8 ? prdata8 : prdata32, exp);
    end
    check_val({tag, "_err"}, use8 ? 32'(pslverr8) : 32'(pslverr32), 32'(exp_err));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_exp(input logic [7:0] off, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    apb_read(16'(off), 1'b0, tag);
  endtask

  task automatic read_all_zero(input string tag);
    for (int r = 0; r < 7; r++) begin
      read_exp(8'(r * 4), 32'h0, $sformatf("%s_r%0d", tag, r));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    preset_n = 1'b1;
    tick(1);
    check_val("rst_gpio_o", gpio_o32, 32'h0);
    check_val("rst_gpio_e", gpio_e32, 32'h0);
    check_val("rst_irq", 32'(irq32), 32'h0);
    check_val("rst_pready", 32'(pready32), 32'h1);
    check_val("rst_prdata_idle", prdata32, 32'h0);
    read_all_zero("rst");

    // Byte strobes and direct pad outputs
    apb_write(16'(OFF_DOUT), 32'hA5A5_1234, 4'b0011, 1'b0, "w_dout");
    read_exp(OFF_DOUT, 32'h0000_1234, "dout_strb");
    check_val("gpio_o32", gpio_o32, 32'h0000_1234);
    check_val("gpio_o8", 32'(gpio_o8), 32'h34);
    apb_write(16'(OFF_OE), 32'hFFFF_FFFF, 4'b1111, 1'b0, "w_oe");
    check_val("gpio_e_all", gpio_e32, 32'hFFFF_FFFF);

    // Rise edge latency and registered irq
    apb_write(16'(OFF_RISE_EN), 32'h1, 4'b1111, 1'b0, "w_rise_en");
    apb_write(16'(OFF_IRQ_EN), 32'h1, 4'b1111, 1'b0, "w_irq_en");
    @(posedge pclk); #1;
    gpio_i[0] = 1'b1;
    tick(2);
    check_val("irq_k2", 32'(irq32), 32'h0);
    tick(1);
    check_val("irq_k3", 32'(irq32), 32'h0);
    tick(1);
    check_val("irq_k4", 32'(irq32), 32'h1);
    read_exp(OFF_IRQ_STAT, 32'h1, "stat_rise");
    read_exp(OFF_DIN, 32'h1, "din_1");

    // New edge beats a same-cycle clear
    gpio_i[0] = 1'b0;
    tick(4);
    read_exp(OFF_IRQ_STAT, 32'h1, "stat_no_fall");
    @(posedge pclk); #1;
    gpio_i[0] = 1'b1;
    apb_write(16'(OFF_IRQ_STAT), 32'h1, 4'b1111, 1'b0, "w_stat_race");
    read_exp(OFF_IRQ_STAT, 32'h1, "stat_race");

    // Plain clear, irq drops one cycle later
    apb_write(16'(OFF_IRQ_STAT), 32'h1, 4'b1111, 1'b0, "w_stat_clr");
    check_val("irq_after_clr", 32'(irq32), 32'h1);
    tick(1);
    check_val("irq_fell", 32'(irq32), 32'h0);
    read_exp(OFF_IRQ_STAT, 32'h0, "stat_clr");

    // Fall edge latches while masked from irq
    gpio_i[1] = 1'b1;
    tick(4);
    apb_write(16'(OFF_FALL_EN), 32'h2, 4'b1111, 1'b0, "w_fall_en");
    gpio_i[1] = 1'b0;
    tick(5);
    read_exp(OFF_IRQ_STAT, 32'h2, "stat_fall");
    check_val("irq_masked", 32'(irq32), 32'h0);

    // Unmapped offset and read-only DIN
    exp_q.push_back(32'h0);
    apb_read(16'(OFF_UNMAPPED), 1'b1, "rd_unmapped");
    apb_write(16'(OFF_UNMAPPED), 32'hFFFF_FFFF, 4'b1111, 1'b1, "w_unmapped");
    read_exp(OFF_DOUT, 32'h0000_1234, "dout_after_unmapped");
    apb_write(16'(OFF_DIN), 32'h0000_00F0, 4'b1111, 1'b0, "w_din");
    read_exp(OFF_DIN, 32'h1, "din_unchanged");

    // Narrow instance drops bits above GPIO
    apb_write(16'(OFF_DOUT), 32'hFFFF_FFFF, 4'b1111, 1'b0, "w_dout_full");
    use8 = 1'b1;
    read_exp(OFF_DOUT, 32'h0000_00FF, "dout8");
    use8 = 1'b0;
    read_exp(OFF_DOUT, 32'hFFFF_FFFF, "dout32");

    // Reset asserted across the commit edge of a write
    gpio_i = '0;
    tick(4);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 16'(OFF_RISE_EN); pwdata = 32'h0000_FFFF; pstrb = 4'b1111;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2;
    preset_n = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #2;
    preset_n = 1'b1;
    check_val("mid_rst_gpio_o", gpio_o32, 32'h0);
    check_val("mid_rst_gpio_e", gpio_e32, 32'h0);
    check_val("mid_rst_gpio_o8", 32'(gpio_o8), 32'h0);
    read_all_zero("mid_rst32");
    use8 = 1'b1;
    read_all_zero("mid_rst8");
    use8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
